// File: rtl/serializer_frame_tx_pkg.sv
// Shared definitions for the framed serial transmitter: state encoding,
// idle line level and frame length helper.
package serializer_frame_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic IDLE_LEVEL = 1'b1;

   // Cycles per frame: start + data bits + optional parity + stop.
   function automatic int frame_len(input int data_width, input int parity_en);
      return 2 + data_width + parity_en;
   endfunction

endpackage

// File: rtl/serializer_frame_tx_if.sv
// Valid/ready word handshake feeding the framed serial transmitter.
interface serializer_frame_tx_if #(
   parameter int DATA_WIDTH = 8
) ();

   logic [DATA_WIDTH-1:0] data_in;
   logic                  data_valid;
   logic                  data_ready;

   modport master (
      output data_in,
      output data_valid,
      input  data_ready
   );

   modport slave (
      input  data_in,
      input  data_valid,
      output data_ready
   );

endinterface

// File: rtl/serializer_frame_tx.sv
// Parallel-to-serial transmitter: start bit, data LSB-first, optional parity,
// stop bit, one bit per clock. All outputs are registered.
module serializer_frame_tx
   import serializer_frame_tx_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int Counter_Width = 3,
   parameter bit PARITY_EN     = 1'b1,
   parameter bit PARITY_ODD    = 1'b0
) (
   input  logic                  clock_in,
   input  logic                  reset_n,
   serializer_frame_tx_if.slave  tx,
   output logic                  serial_out,
   output logic                  busy,
   output logic                  frame_done
);

   localparam logic [Counter_Width-1:0] LAST_BIT = Counter_Width'(DATA_WIDTH - 1);

   tx_state_t               state, state_nx;
   logic [Counter_Width-1:0] count, count_nx;
   logic [DATA_WIDTH-1:0]    shift_reg, shift_nx;
   logic                     parity_q, parity_nx;
   logic                     data_ready_q, data_ready_nx;
   logic                     serial_nx, busy_nx, done_nx;
   logic                     accept;

   assign tx.data_ready = data_ready_q;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         count        <= '0;
         shift_reg    <= '0;
         parity_q     <= 1'b0;
         data_ready_q <= 1'b0;
         serial_out   <= IDLE_LEVEL;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         state        <= state_nx;
         count        <= count_nx;
         shift_reg    <= shift_nx;
         parity_q     <= parity_nx;
         data_ready_q <= data_ready_nx;
         serial_out   <= serial_nx;
         busy         <= busy_nx;
         frame_done   <= done_nx;
      end
   end

   // Outputs are decoded from the state being entered so they line up with
   // it after the register; shift_reg[0] is the bit on the line during DATA.
   always_comb begin
      state_nx      = state;
      count_nx      = count;
      shift_nx      = shift_reg;
      parity_nx     = parity_q;
      serial_nx     = IDLE_LEVEL;
      busy_nx       = 1'b1;
      done_nx       = 1'b0;
      data_ready_nx = 1'b0;
      accept        = tx.data_valid & data_ready_q;

      case (state)
         IDLE, STOP: begin
            if (accept) begin
               state_nx  = START;
               shift_nx  = tx.data_in;
               parity_nx = (^tx.data_in) ^ PARITY_ODD;
            end else begin
               state_nx  = IDLE;
            end
         end
         START: begin
            state_nx = DATA;
            count_nx = '0;
         end
         DATA: begin
            shift_nx = shift_reg >> 1;
            if (count == LAST_BIT) begin
               count_nx = '0;
               state_nx = PARITY_EN ? PARITY : STOP;
            end else begin
               count_nx = count + 1'b1;
            end
         end
         PARITY: state_nx = STOP;
         default: state_nx = IDLE;
      endcase

      case (state_nx)
         IDLE: begin
            busy_nx       = 1'b0;
            data_ready_nx = 1'b1;
         end
         START:  serial_nx = 1'b0;
         DATA:   serial_nx = shift_nx[0];
         PARITY: serial_nx = parity_nx;
         STOP: begin
            done_nx       = 1'b1;
            data_ready_nx = 1'b1;
         end
         default: busy_nx = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_serializer_frame_tx.sv
// Self-checking bench for serializer_frame_tx: three parity configurations,
// scoreboard of expected per-cycle line/flag values fed at each accept.
module tb_serializer_frame_tx;
   import serializer_frame_tx_pkg::*;

   typedef struct packed {
      logic so;
      logic busy;
      logic done;
      logic ready;
   } exp_t;

   localparam exp_t IDLE_EXP = '{so: 1'b1, busy: 1'b0, done: 1'b0, ready: 1'b1};

   logic       clock_in;
   logic       reset_n;
   logic [7:0] tb_data;
   logic       tb_valid;
   int         sel;

   logic so_a, busy_a, done_a;
   logic so_b, busy_b, done_b;
   logic so_c, busy_c, done_c;
   logic so_obs, busy_obs, done_obs, ready_obs;

   exp_t exp_q[$];
   logic exp_ready;
   int   accept_count;
   int   tests;
   int   fails;

   serializer_frame_tx_if #(.DATA_WIDTH(8)) if_a ();
   serializer_frame_tx_if #(.DATA_WIDTH(8)) if_b ();
   serializer_frame_tx_if #(.DATA_WIDTH(8)) if_c ();

   assign if_a.data_in    = tb_data;
   assign if_b.data_in    = tb_data;
   assign if_c.data_in    = tb_data;
   assign if_a.data_valid = tb_valid && (sel == 0);
   assign if_b.data_valid = tb_valid && (sel == 1);
   assign if_c.data_valid = tb_valid && (sel == 2);

   serializer_frame_tx #(.DATA_WIDTH(8), .Counter_Width(3), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
      .clock_in(clock_in), .reset_n(reset_n), .tx(if_a),
      .serial_out(so_a), .busy(busy_a), .frame_done(done_a));

   serializer_frame_tx #(.DATA_WIDTH(8), .Counter_Width(3), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
      .clock_in(clock_in), .reset_n(reset_n), .tx(if_b),
      .serial_out(so_b), .busy(busy_b), .frame_done(done_b));

   serializer_frame_tx #(.DATA_WIDTH(8), .Counter_Width(3), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_nopar (
      .clock_in(clock_in), .reset_n(reset_n), .tx(if_c),
      .serial_out(so_c), .busy(busy_c), .frame_done(done_c));

   initial begin
      clock_in = 1'b0;
      forever #5 clock_in = ~clock_in;
   end

   always_comb begin
      case (sel)
         1:       {so_obs, busy_obs, done_obs, ready_obs} = {so_b, busy_b, done_b, if_b.data_ready};
         2:       {so_obs, busy_obs, done_obs, ready_obs} = {so_c, busy_c, done_c, if_c.data_ready};
         default: {so_obs, busy_obs, done_obs, ready_obs} = {so_a, busy_a, done_a, if_a.data_ready};
      endcase
   end

   // Reference frame for the selected configuration, queued cycle by cycle.
   task automatic push_frame(input logic [7:0] d, input bit pen, input bit podd);
      exp_q.push_back('{so: 1'b0, busy: 1'b1, done: 1'b0, ready: 1'b0});
      for (int i = 0; i < 8; i++)
         exp_q.push_back('{so: d[i], busy: 1'b1, done: 1'b0, ready: 1'b0});
      if (pen)
         exp_q.push_back('{so: (^d) ^ podd, busy: 1'b1, done: 1'b0, ready: 1'b0});
      exp_q.push_back('{so: 1'b1, busy: 1'b1, done: 1'b1, ready: 1'b1});
   endtask

   always @(posedge clock_in) begin
      if (reset_n && tb_valid && exp_ready) begin
         push_frame(tb_data, sel != 2, sel == 1);
         accept_count++;
      end
   end

   task automatic checkOutput(input string tag, input logic obs, input logic expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic check_cycle(input string tag);
      exp_t e;
      @(negedge clock_in);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = IDLE_EXP;
      checkOutput({tag, "_serial"}, so_obs, e.so);
      checkOutput({tag, "_busy"}, busy_obs, e.busy);
      checkOutput({tag, "_done"}, done_obs, e.done);
      checkOutput({tag, "_ready"}, ready_obs, e.ready);
      exp_ready = e.ready;
   endtask

   task automatic drain(input string tag, input int n);
      for (int i = 0; i < n; i++) check_cycle(tag);
   endtask

   // Offer a word and run checked cycles until it is taken (bounded).
   task automatic applyStimulus(input string tag, input logic [7:0] d, input bit keep_valid);
      int n0;
      bit taken;
      n0       = accept_count;
      taken    = 1'b0;
      tb_data  = d;
      tb_valid = 1'b1;
      for (int i = 0; i < 30 && !taken; i++) begin
         check_cycle(tag);
         taken = (accept_count != n0);
      end
      tests++;
      if (!taken) begin
         fails++;
         $error("[TB] FAIL %s_accept_timeout observed=no_accept expected=accept", tag);
      end
      if (!keep_valid) tb_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tests        = 0;
      fails        = 0;
      accept_count = 0;
      exp_ready    = 1'b0;
      sel          = 0;
      tb_valid     = 1'b0;
      tb_data      = 8'h00;
      reset_n      = 1'b0;

      repeat (2) @(negedge clock_in);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         checkOutput("reset_serial", so_obs, 1'b1);
         checkOutput("reset_busy", busy_obs, 1'b0);
         checkOutput("reset_ready", ready_obs, 1'b0);
         checkOutput("reset_done", done_obs, 1'b0);
      end
      sel = 0;
      @(negedge clock_in);
      reset_n = 1'b1;
      check_cycle("post_reset_idle");

      // Single 0xA5 frame with even parity.
      applyStimulus("a5", 8'hA5, 1'b0);
      drain("a5", frame_len(8, 1) + 1);

      // Held valid: 0x80 accepted in the STOP cycle of 0x01.
      applyStimulus("b2b_first", 8'h01, 1'b1);
      applyStimulus("b2b_second", 8'h80, 1'b0);
      drain("b2b", frame_len(8, 1) + 1);

      // Odd parity of zero word, then even parity of 0x07.
      sel = 1;
      applyStimulus("odd_00", 8'h00, 1'b0);
      drain("odd_00", frame_len(8, 1) + 1);
      sel = 0;
      applyStimulus("even_07", 8'h07, 1'b0);
      drain("even_07", frame_len(8, 1) + 1);

      // No parity bit: two back-to-back 0xFF frames.
      sel = 2;
      applyStimulus("nopar_ff1", 8'hFF, 1'b1);
      applyStimulus("nopar_ff2", 8'hFF, 1'b0);
      drain("nopar", frame_len(8, 0) + 1);
      sel = 0;
      check_cycle("sel_back");

      // Reset during data bit 4 abandons the frame asynchronously.
      applyStimulus("midreset", 8'h5A, 1'b0);
      drain("midreset_bits", 5);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_serial", so_obs, 1'b1);
      checkOutput("midreset_busy", busy_obs, 1'b0);
      checkOutput("midreset_ready", ready_obs, 1'b0);
      exp_q.delete();
      exp_ready = 1'b0;
      @(negedge clock_in);
      @(negedge clock_in);
      reset_n = 1'b1;
      drain("after_midreset", 12);

      // A word offered mid-frame is ignored.
      applyStimulus("ignore_55", 8'h55, 1'b0);
      drain("ignore_55", 3);
      tb_data  = 8'h3C;
      tb_valid = 1'b1;
      check_cycle("ignore_3c");
      tb_valid = 1'b0;
      drain("ignore_tail", frame_len(8, 1) + 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
